// File: rtl/apb_native_master.sv
// Bridge from the core's native MMIO port to an APB initiator with SETUP/ACCESS
// sequencing, wait-state handling, slave error reporting and an optional ACCESS timeout.
`timescale 1ns/1ps
module apb_native_master #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              nat_sel,
  input  logic              nat_write,
  input  logic [ADDR_W-1:0] nat_addr,
  input  logic [DATA_W-1:0] nat_wdata,
  output logic [DATA_W-1:0] nat_rdata,
  output logic              nat_busy,
  output logic              nat_done,
  output logic              nat_err,
  output logic              apbm_sel,
  output logic              apbm_enable,
  output logic              apbm_write,
  output logic [ADDR_W-1:0] apbm_addr,
  output logic [DATA_W-1:0] apbm_wdata,
  input  logic [DATA_W-1:0] apbm_rdata,
  input  logic              apbm_ready,
  input  logic              apbm_slverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              enable_q, enable_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      enable_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      enable_q <= enable_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Every output is computed one cycle ahead here, so all of them leave flops.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    enable_d = enable_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (nat_sel) begin
          state_d  = SETUP;
          sel_d    = 1'b1;
          enable_d = 1'b0;
          busy_d   = 1'b1;
          write_d  = nat_write;
          addr_d   = nat_addr;
          wdata_d  = nat_wdata;
          cnt_d    = '0;
        end
      end
      SETUP: begin
        state_d  = ACCESS;
        enable_d = 1'b1;
      end
      ACCESS: begin
        // A real pready always wins over a timeout landing in the same cycle.
        if (apbm_ready || (TIMEOUT_EN && cnt_q == CNT_LAST)) begin
          state_d  = IDLE;
          sel_d    = 1'b0;
          enable_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
          if (apbm_ready) begin
            rdata_d = write_q ? '0 : apbm_rdata;
            err_d   = apbm_slverr;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        sel_d    = 1'b0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign nat_rdata   = rdata_q;
  assign nat_busy    = busy_q;
  assign nat_done    = done_q;
  assign nat_err     = err_q;
  assign apbm_sel    = sel_q;
  assign apbm_enable = enable_q;
  assign apbm_write  = write_q;
  assign apbm_addr   = addr_q;
  assign apbm_wdata  = wdata_q;

endmodule
